// File: rtl/tinker_mem_arbiter.sv
// tinker_mem_arbiter: shares one multi-cycle memory port between instruction fetch and data accesses.
// Define ARB_STATS_EN to add the stat_fetch_stall_o / stat_data_cnt_o counters.
module tinker_mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_valid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_valid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_fetch_stall_o,
  output logic [31:0]       stat_data_cnt_o
`endif
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [SW-1:0]     starve_q;
  logic [SW-1:0]     starve_d;
  logic              if_gnt_q;
  logic              if_valid_q;
  logic [31:0]       if_rdata_q;
  logic              d_gnt_q;
  logic              d_valid_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              starve_hit;
  logic              grant_if;
  logic              grant_data;

  // Winner selection in IDLE and the next value of the starvation counter.
  always_comb begin
    starve_hit = (STARVE_MAX != 0) && (starve_q >= SW'(STARVE_MAX));
    grant_if   = (state_q == IDLE) && if_req_i && (!d_req_i || starve_hit);
    grant_data = (state_q == IDLE) && d_req_i && !grant_if;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_data && if_req_i && (starve_q < SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Access sequencer: grant, hold the memory strobes for MEM_LAT cycles, then capture and pulse valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      if_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_gnt_q     <= 1'b0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      starve_q   <= starve_d;
      case (state_q)
        IDLE: begin
          if (grant_if) begin
            state_q    <= BUSY_I;
            if_gnt_q   <= 1'b1;
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= if_addr_i;
            cnt_q      <= CW'(MEM_LAT - 1);
          end else if (grant_data) begin
            state_q     <= BUSY_D;
            d_gnt_q     <= 1'b1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= d_we_i;
            mem_addr_q  <= d_addr_i;
            mem_wdata_q <= d_wdata_i;
            cnt_q       <= CW'(MEM_LAT - 1);
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY_I, BUSY_D: begin
          if (cnt_q == '0) begin
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (state_q == BUSY_I) begin
              if_valid_q <= 1'b1;
              if_rdata_q <= mem_rdata_i[31:0];
            end else begin
              d_valid_q <= 1'b1;
              // mem_we_q still reflects the access type here; stores leave d_rdata alone
              if (!mem_we_q) begin
                d_rdata_q <= mem_rdata_i;
              end else begin
                d_rdata_q <= d_rdata_q;
              end
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt_o    = if_gnt_q;
  assign if_valid_o  = if_valid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_gnt_o     = d_gnt_q;
  assign d_valid_o   = d_valid_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

`ifdef ARB_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] data_cnt_q;

  // Free-running, wrapping counters of fetch stall cycles and data grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      data_cnt_q  <= '0;
    end else begin
      if (if_req_i && !if_gnt_q) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (grant_data) begin
        data_cnt_q <= data_cnt_q + 32'd1;
      end else begin
        data_cnt_q <= data_cnt_q;
      end
    end
  end

  assign stat_fetch_stall_o = stall_cnt_q;
  assign stat_data_cnt_o    = data_cnt_q;
`endif

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Self-checking bench for tinker_mem_arbiter: directed vector table, starvation/reset sequences,
// and randomized traffic against a transaction-phase reference model.
module tb_tinker_mem_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] mem_rdata;
  logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we;
  logic [31:0] if_rdata;
  logic [63:0] d_rdata, mem_addr, mem_wdata;
`ifdef ARB_STATS_EN
  logic [31:0] stat_fetch_stall, stat_data_cnt;
`endif
  logic [5:0]  ctl;

  int total = 0;
  int bad   = 0;

  // reference model state: phase 0 = idle, 1..MEM_LAT = access, MEM_LAT+1 = valid cycle
  int          ph;
  bit          own_f;
  bit          m_we;
  logic [63:0] m_addr, m_wd, exp_drd;
  logic [31:0] exp_ird;
  int          starve, stall_n, dcnt_n;

  typedef struct {
    logic        ir;
    logic        dr;
    logic        dwe;
    logic [63:0] rd;
    logic [5:0]  ctl;
    logic [63:0] addr;
    logic [31:0] ird;
    logic [63:0] drd;
  } vec_t;
  vec_t vt[13];

  tinker_mem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_gnt_o   (if_gnt),
    .if_valid_o (if_valid),
    .if_rdata_o (if_rdata),
    .d_req_i    (d_req),
    .d_we_i     (d_we),
    .d_addr_i   (d_addr),
    .d_wdata_i  (d_wdata),
    .d_gnt_o    (d_gnt),
    .d_valid_o  (d_valid),
    .d_rdata_o  (d_rdata),
    .mem_en_o   (mem_en),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
`ifdef ARB_STATS_EN
    ,
    .stat_fetch_stall_o(stat_fetch_stall),
    .stat_data_cnt_o   (stat_data_cnt)
`endif
  );

  assign ctl = {if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0; own_f = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0;
    exp_ird = '0; exp_drd = '0; starve = 0; stall_n = 0; dcnt_n = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 64'(ctl), 64'd0);
    chk("rst_if_rdata", 64'(if_rdata), 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // one clock of the reference model followed by comparison of every output
  task automatic tick();
    bit fetch, en;
    if (if_req && !(ph == 1 && own_f)) stall_n++;
    if (ph == MEM_LAT) begin
      if (own_f) exp_ird = mem_rdata[31:0];
      else if (!m_we) exp_drd = mem_rdata;
    end
    if (ph == 0 || ph == MEM_LAT + 1) begin
      if (if_req || d_req) begin
        fetch = if_req && (!d_req || (STARVE_MAX > 0 && starve >= STARVE_MAX));
        own_f = fetch;
        ph = 1;
        if (fetch) begin
          m_addr = if_addr; m_we = 1'b0; starve = 0;
        end else begin
          m_addr = d_addr; m_we = d_we; m_wd = d_wdata; dcnt_n++;
          if (if_req && starve < STARVE_MAX) starve++;
        end
      end else begin
        ph = 0;
      end
    end else begin
      ph++;
    end
    @(posedge clk);
    #1;
    en = (ph >= 1 && ph <= MEM_LAT);
    chk("rnd_ctl", 64'(ctl), 64'({ph == 1 && own_f, ph == MEM_LAT + 1 && own_f,
                                 ph == 1 && !own_f, ph == MEM_LAT + 1 && !own_f,
                                 en, en && !own_f && m_we}));
    if (en) chk("rnd_mem_addr", mem_addr, m_addr);
    if (en && !own_f) chk("rnd_mem_wdata", mem_wdata, m_wd);
    chk("rnd_if_rdata", 64'(if_rdata), 64'(exp_ird));
    chk("rnd_d_rdata", d_rdata, exp_drd);
`ifdef ARB_STATS_EN
    chk("rnd_stat_stall", 64'(stat_fetch_stall), 64'(stall_n));
    chk("rnd_stat_data", 64'(stat_data_cnt), 64'(dcnt_n));
`endif
  endtask

  // both requesters held high: expect STARVE_MAX data grants, then one fetch grant, repeating
  task automatic run_pattern(input int n, input string nm);
    int w;
    bit exp_f;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    for (int k = 0; k < n; k++) begin
      w = 0;
      do begin
        @(posedge clk);
        #1;
        w++;
      end while (!(if_gnt || d_gnt) && w < 8);
      exp_f = ((k % (STARVE_MAX + 1)) == STARVE_MAX);
      chk($sformatf("%s_grant%0d", nm, k), 64'({if_gnt, d_gnt}), exp_f ? 64'd2 : 64'd1);
      if (!(if_gnt || d_gnt)) break;
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (MEM_LAT + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_rdata = '0;
    if_addr = 64'h2000; d_addr = 64'h1000; d_wdata = 64'hDEAD;
    model_reset();

    // ctl = {if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we}; rd is mem_rdata before the edge
    vt[0]  = '{1'b1, 1'b0, 1'b0, 64'h0,                  6'b100010, 64'h2000, 32'h0,        64'h0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 64'h0,                  6'b000010, 64'h2000, 32'h0,        64'h0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 64'hA5A5_0001,          6'b010000, 64'h2000, 32'hA5A50001, 64'h0};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 64'h0,                  6'b001011, 64'h1000, 32'hA5A50001, 64'h0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 64'h0,                  6'b000011, 64'h1000, 32'hA5A50001, 64'h0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 64'hBAD0,               6'b000100, 64'h1000, 32'hA5A50001, 64'h0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 64'h0,                  6'b100010, 64'h2000, 32'hA5A50001, 64'h0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 64'h0,                  6'b000010, 64'h2000, 32'hA5A50001, 64'h0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 64'h1234_5678_CAFE_F00D, 6'b010000, 64'h2000, 32'hCAFEF00D, 64'h0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 64'h0,                  6'b100010, 64'h2000, 32'hCAFEF00D, 64'h0};
    vt[10] = '{1'b0, 1'b1, 1'b0, 64'h0,                  6'b000010, 64'h2000, 32'hCAFEF00D, 64'h0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 64'h1111_2222,          6'b010000, 64'h2000, 32'h11112222, 64'h0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 64'h0,                  6'b000000, 64'h2000, 32'h11112222, 64'h0};

    do_reset();

    // fetch-only access, store with fetch contention, d_req pulse ignored while busy
    for (int i = 0; i < 13; i++) begin
      if_req = vt[i].ir; d_req = vt[i].dr; d_we = vt[i].dwe; mem_rdata = vt[i].rd;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ctl", i), 64'(ctl), 64'(vt[i].ctl));
      if (vt[i].ctl[1]) chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].addr);
      if (vt[i].ctl[0]) chk($sformatf("vec%0d_wdata", i), mem_wdata, 64'hDEAD);
      chk($sformatf("vec%0d_if_rdata", i), 64'(if_rdata), 64'(vt[i].ird));
      chk($sformatf("vec%0d_d_rdata", i), d_rdata, vt[i].drd);
    end

    run_pattern(15, "starve");

    // reset in the first cycle of a store (one latency cycle left)
    begin
      int w;
      if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 64'h3000;
      w = 0;
      do begin
        @(posedge clk);
        #1;
        w++;
      end while (!(if_gnt || d_gnt) && w < 8);
      chk("abort_first_grant", 64'({if_gnt, d_gnt, mem_we}), 64'd3);
      #2 rst = 1'b1;
      #1;
      chk("abort_outputs_drop", 64'(ctl), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk);
        #1;
        chk($sformatf("abort_quiet%0d", c), 64'(ctl), 64'd0);
      end
      run_pattern(5, "abort_starve");
    end

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      tick();
      if (ph == 1 && own_f) if_req = 1'b0;
      else if (if_req && $urandom_range(0, 40) == 0) if_req = 1'b0;
      if (ph == 1 && !own_f) d_req = 1'b0;
      else if (d_req && $urandom_range(0, 40) == 0) d_req = 1'b0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = {$urandom, $urandom};
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
      end
      mem_rdata = {$urandom, $urandom};
    end

`ifdef ARB_STATS_EN
    // both requesters held high until ten data grants have been made
    do_reset();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    begin
      int g;
      g = 0;
      while (dcnt_n < 10 && g < 200) begin
        mem_rdata = {$urandom, $urandom};
        tick();
        g++;
      end
    end
    chk("stats_data_cnt", 64'(stat_data_cnt), 64'd10);
    chk("stats_fetch_stall", 64'(stat_fetch_stall), 64'(stall_n));
    if_req = 1'b0; d_req = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
